branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor in the fetch stage, directly upstream of the PC-select mux.
- Each cycle it looks up the current fetch PC and produces the 2-bit PC-source select plus a predicted branch target. The mux uses these to pick between next-sequential PC and predicted target.
- Execute stage feeds resolved branch outcomes back to train an untagged 2-bit-counter BHT and a tagged BTB.

Parameters:
- IDX_BITS, 4, log2 of table entries (16 entries); index = pc[IDX_BITS+1:2].
- ADDR_W, 32, address width; tag = pc[ADDR_W-1:IDX_BITS+2].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_pc  input  ADDR_W  PC currently being fetched.
- pred_taken  output  1  prediction for fetch_pc: branch taken.
- pred_target  output  ADDR_W  predicted target; 0 when pred_taken=0.
- pc_src  output  2  mux select: 2'b10 (branch target) when pred_taken, else 2'b00.
- upd_valid  input  1  resolved conditional branch this cycle.
- upd_pc  input  ADDR_W  PC of resolved branch.
- upd_taken  input  1  actual outcome.
- upd_target  input  ADDR_W  actual taken target.
- upd_mispredict  input  1  execute detected misprediction (statistics only).

Behaviour:
- Storage per entry:
  - BHT: 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
  - BTB: valid bit, tag, target.
- Reset (async, immediate): all counters = 2'b01, all BTB valid = 0, tags/targets = 0. Outputs then read pred_taken=0, pc_src=2'b00, pred_target=0.
- Lookup is combinational, zero latency, from registered state only:
  - hit = btb_valid[idx] && btb_tag[idx] == tag(fetch_pc).
  - pred_taken = hit && bht[idx][1].
- Update on rising clk when upd_valid=1, visible to lookups the next cycle:
  - Counter at idx(upd_pc): increment if upd_taken, else decrement.
  - Saturating: 11 + taken stays 11; 00 + not-taken stays 00.
  - If upd_taken: BTB[idx] <= {valid=1, tag(upd_pc), upd_target}, overwriting any aliasing entry.
  - If not taken: BTB untouched.
- upd_valid=0: no state change.
- Same-index read/write in one cycle: lookup returns pre-update contents. No bypass.
- Aliasing: counters are untagged and shared between PCs with equal index. The BTB tag check prevents wrong-target prediction.
- Reset asserted mid-update: reset wins; the update is discarded.
- pc_src never drives 2'b01 or 2'b11; jump select is owned by decode.
- Targets are stored verbatim; no alignment check.

Optional Feature:
- Macro BP_PERF_CNT_EN.
- When defined, adds two 32-bit output ports:
  - perf_branches: counts cycles with upd_valid=1.
  - perf_mispredicts: counts cycles with upd_valid && upd_mispredict.
- Both counters reset to 0, wrap modulo 2^32, no saturation.
- When undefined, the ports and counters do not exist and core behaviour is identical.

Decomposition:
- Shared package holds:
  - counter encodings (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11);
  - PC-source encodings (PCSRC_SEQ=2'b00, PCSRC_JUMP=2'b01, PCSRC_BRANCH=2'b10), shared with the PC mux;
  - BHT reset value.
- One sub-module is natural: bp_sat_counter, a pure combinational next-state function (2-bit state, taken in, next state out), replicated in the update path.

Test Plan:
1. Reset, fetch_pc=0x100 → pred_taken=0, pc_src=2'b00, pred_target=0.
2. One update {pc=0x100, taken=1, target=0x80} → next cycle fetch 0x100 gives pred_taken=1 (01→10), pc_src=2'b10, pred_target=0x80.
3. Three taken updates then one not-taken at 0x100 → counter 11 then 10; still predicted taken. A second not-taken gives 01 → pred_taken=0, pc_src=00.
4. Train 0x100 taken to 0x80, then fetch alias 0x140 (same index, different tag) → pred_taken=0. Taken update {0x140→0x200} → 0x140 predicts 0x200 and 0x100 now misses.
5. upd_valid on 0x100 same cycle as fetch_pc=0x100 → that cycle shows old prediction; new prediction appears the following cycle. Assert reset during an upd_valid cycle → tables return to reset state, update lost.
6. With BP_PERF_CNT_EN: 5 updates, 2 flagged upd_mispredict → perf_branches=5, perf_mispredicts=2. Reset → both 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the fetch-stage branch predictor and the PC-select mux.
// Holds 2-bit counter states, PC-source select codes, BHT reset value and
// default table geometry.
package branch_predictor_pkg;

  localparam int unsigned BP_IDX_BITS = 4;
  localparam int unsigned BP_ADDR_W   = 32;

  // 2-bit saturating counter states
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // PC-source mux select codes (jump select is owned by decode)
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_BRANCH = 2'b10;

  localparam logic [1:0] BHT_RESET = WNT;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: next-state function of a 2-bit saturating branch counter.
// Ports:
//   state        - current counter value
//   taken        - resolved branch outcome
//   next_state_c - counter value after training (combinational)
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state_c
);

  // Step toward the observed outcome, holding at the strong ends
  always_comb begin
    next_state_c = state;
    if (taken) begin
      if (state != ST) next_state_c = state + 2'd1;
    end else begin
      if (state != SNT) next_state_c = state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: untagged 2-bit BHT plus tagged BTB for the fetch stage.
// Optional feature macro: BP_PERF_CNT_EN (adds perf_branches/perf_mispredicts).
// Ports:
//   clk, reset        - clock, async active-high reset
//   fetch_pc          - PC being fetched; looked up combinationally
//   pred_taken        - predicted taken (BTB hit and counter MSB)
//   pred_target       - predicted target, 0 when not taken
//   pc_src            - PC mux select: PCSRC_BRANCH or PCSRC_SEQ
//   upd_*             - resolved branch from execute; trains tables on clk
//   perf_branches     - (optional) count of update cycles
//   perf_mispredicts  - (optional) count of mispredicted update cycles
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = BP_IDX_BITS,
  parameter int unsigned ADDR_W   = BP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [1:0]        pc_src,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispredicts
`endif
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_W   = ADDR_W - IDX_BITS - 2;

  logic [1:0]        bht        [ENTRIES];
  logic [1:0]        bht_next   [ENTRIES];
  logic              btb_valid  [ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [ENTRIES];
  logic [ADDR_W-1:0] btb_target [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_W-1:0]    fetch_tag;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                hit;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = fetch_pc[ADDR_W-1:IDX_BITS+2];
  assign upd_idx   = upd_pc[IDX_BITS+1:2];
  assign upd_tag   = upd_pc[ADDR_W-1:IDX_BITS+2];

  // Per-entry counter training; only the indexed result is written back
  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    bp_sat_counter u_ctr (
      .state        (bht[g]),
      .taken        (upd_taken),
      .next_state_c (bht_next[g])
    );
  end

  // Lookup reads registered state only, so a same-cycle update is not bypassed
  always_comb begin
    hit         = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    pred_taken  = hit && bht[fetch_idx][1];
    pred_target = pred_taken ? btb_target[fetch_idx] : '0;
    pc_src      = pred_taken ? PCSRC_BRANCH : PCSRC_SEQ;
  end

  // Table training; taken branches overwrite any aliasing BTB entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        bht[i]        <= BHT_RESET;
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (upd_valid) begin
      bht[upd_idx] <= bht_next[upd_idx];
      if (upd_taken) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= upd_target;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  // Free-running statistics, wrap modulo 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_branches    <= 32'd0;
      perf_mispredicts <= 32'd0;
    end else if (upd_valid) begin
      perf_branches <= perf_branches + 32'd1;
      if (upd_mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`else
  logic unused_mispredict;
  assign unused_mispredict = upd_mispredict;
`endif

  // Byte-offset bits never take part in index or tag
  logic unused_pc_low;
  assign unused_pc_low = ^{fetch_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed plan plus random traffic,
// checked against an arithmetic reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pc_src;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  branch_predictor dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pc_src         (pc_src),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        taken;
    logic [31:0] target;
    logic [31:0] branches;
    logic [31:0] mispredicts;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: per-index counter 0..3, BTB remembers the full trained PC
  int          m_ctr [16];
  bit          m_bv  [16];
  logic [31:0] m_bpc [16];
  logic [31:0] m_btgt[16];
  logic [31:0] m_br, m_mis;

  bit          pend_v;
  logic [31:0] pend_pc, pend_tgt;
  bit          pend_t, pend_m;
  int          step_id = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_ctr[i] = 1; m_bv[i] = 0; m_bpc[i] = '0; m_btgt[i] = '0;
    end
    m_br = '0; m_mis = '0;
  endtask

  task automatic model_update(input logic [31:0] pc, input bit t,
                              input logic [31:0] tgt, input bit mis);
    int i;
    i = idx_of(pc);
    if (t) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
    else   m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
    if (t) begin
      m_bv[i] = 1; m_bpc[i] = pc; m_btgt[i] = tgt;
    end
    m_br = m_br + 32'd1;
    if (mis) m_mis = m_mis + 32'd1;
  endtask

  // One cycle: commit last cycle's update to the model, drive new inputs,
  // queue the expected lookup (model, or a constant for directed steps)
  task automatic step(input bit rst, input logic [31:0] fpc, input bit uv,
                      input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                      input bit um, input bit directed, input bit d_taken,
                      input logic [31:0] d_target);
    exp_t e;
    int i;
    @(posedge clk); #1;
    if (pend_v) model_update(pend_pc, pend_t, pend_tgt, pend_m);
    pend_v = 0;
    reset = rst; fetch_pc = fpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utgt; upd_mispredict = um;
    if (rst) model_reset();
    else if (uv) begin
      pend_v = 1; pend_pc = upc; pend_t = ut; pend_tgt = utgt; pend_m = um;
    end
    step_id++;
    e.id = step_id;
    if (directed) begin
      e.taken = d_taken; e.target = d_target;
    end else begin
      i = idx_of(fpc);
      e.taken  = m_bv[i] && (m_bpc[i] / 64 == fpc / 64) && (m_ctr[i] >= 2);
      e.target = e.taken ? m_btgt[i] : 32'd0;
    end
    e.branches = m_br; e.mispredicts = m_mis;
    q.push_back(e);
  endtask

  // Monitor: lookup outputs are valid every cycle; compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (pred_taken !== e.taken) begin
          errors++;
          $display("FAIL pred_taken step %0d got %0b want %0b", e.id, pred_taken, e.taken);
        end
        checks++;
        if (pc_src !== (e.taken ? 2'b10 : 2'b00)) begin
          errors++;
          $display("FAIL pc_src step %0d got %b want %b", e.id, pc_src, e.taken ? 2'b10 : 2'b00);
        end
        checks++;
        if (pred_target !== e.target) begin
          errors++;
          $display("FAIL pred_target step %0d got %h want %h", e.id, pred_target, e.target);
        end
`ifdef BP_PERF_CNT_EN
        checks++;
        if (perf_branches !== e.branches) begin
          errors++;
          $display("FAIL perf_branches step %0d got %0d want %0d", e.id, perf_branches, e.branches);
        end
        checks++;
        if (perf_mispredicts !== e.mispredicts) begin
          errors++;
          $display("FAIL perf_mispredicts step %0d got %0d want %0d", e.id, perf_mispredicts, e.mispredicts);
        end
`endif
      end
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] tg, ix, lo;
    tg = 32'($urandom_range(3, 5));
    ix = 32'($urandom_range(0, 3));
    lo = 32'($urandom_range(0, 3));
    return tg * 64 + ix * 4 + lo;
  endfunction

  initial begin
    pend_v = 0;
    model_reset();
    // 1: reset state
    step(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
    // 2 and 5: same-cycle update shows old prediction, new one next cycle
    step(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 1, 0, 0);
    step(0, 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h80);
    // 3: saturate at 11, then two not-taken drop to 01
    step(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 1, 1, 32'h80);
    step(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 1, 1, 32'h80);
    step(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 1, 1, 32'h80);
    step(0, 32'h100, 1, 32'h100, 0, 32'h0, 1, 1, 1, 32'h80);
    step(0, 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h80);
    step(0, 32'h100, 1, 32'h100, 0, 32'h0, 1, 1, 1, 32'h80);
    step(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
    // 4: aliasing at index 0 between 0x100 and 0x140
    step(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 1, 0, 0);
    step(0, 32'h140, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h80);
    step(0, 32'h140, 1, 32'h140, 1, 32'h200, 0, 1, 0, 0);
    step(0, 32'h140, 0, 0, 0, 0, 0, 1, 1, 32'h200);
    step(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
    // 5: reset during an update discards it
    step(1, 32'h140, 1, 32'h140, 1, 32'h300, 1, 1, 0, 0);
    step(0, 32'h140, 0, 0, 0, 0, 0, 1, 0, 0);
    // 6: five updates, two mispredicts (perf counters via model)
    step(0, 32'h100, 1, 32'h104, 1, 32'h10, 1, 0, 0, 0);
    step(0, 32'h104, 1, 32'h104, 1, 32'h10, 0, 0, 0, 0);
    step(0, 32'h104, 1, 32'h108, 0, 32'h0, 1, 0, 0, 0);
    step(0, 32'h108, 1, 32'h104, 1, 32'h10, 0, 0, 0, 0);
    step(0, 32'h104, 1, 32'h10C, 0, 32'h0, 0, 0, 0, 0);
    step(0, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);
    // Random traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) == 0), rand_pc(), bit'($urandom_range(0, 1)),
           rand_pc(), bit'($urandom_range(0, 1)), $urandom(),
           bit'($urandom_range(0, 1)), 0, 0, 0);
    end
    step(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Drain with a bounded wait
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
